// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the P2 async FIFO: read pointer, write-pointer sync, empty and output port.
// Optional macro FIFO_RD_LEVEL_EN adds a registered rd_level occupancy output.
module fifo_rd_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [ADDR_W:0]   wr_ptr_gray_in,
  output logic [ADDR_W:0]   rd_ptr_gray_out,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_W:0]   rd_level
`endif
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W:0]     sync1_q, sync2_q;
  logic [ADDR_W:0]     rd_ptr_bin_q, rd_ptr_gray_q;
  logic [ADDR_W:0]     ptr_next;
  logic [DATA_W-1:0]   dout_q;
  logic                dout_valid_q;

  assign empty           = (sync2_q == rd_ptr_gray_q);
  assign ptr_next        = rd_ptr_bin_q + {{ADDR_W{1'b0}}, 1'b1};
  assign rd_ptr_gray_out = rd_ptr_gray_q;
  assign mem_rd_addr     = rd_ptr_bin_q[ADDR_W-1:0];
  assign dout            = dout_q;
  assign dout_valid      = dout_valid_q;

  // Gated by reset so the RAM never sees a strobe while the controller is being cleared.
  always_comb begin
    mem_rd_en = 1'b0;
    if (reset_n && !empty) begin
      mem_rd_en = (state_q == StIdle) || ((state_q == StHold) && dout_ready);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      state_q       <= StIdle;
    end else begin
      sync1_q <= wr_ptr_gray_in;
      sync2_q <= sync1_q;
      if (mem_rd_en) begin
        rd_ptr_bin_q  <= ptr_next;
        rd_ptr_gray_q <= ptr_next ^ (ptr_next >> 1);
      end
      case (state_q)
        StIdle: begin
          dout_valid_q <= 1'b0;
          if (mem_rd_en) state_q <= StFetch;
        end
        StFetch: begin
          dout_q       <= mem_rd_data;
          dout_valid_q <= 1'b1;
          state_q      <= StHold;
        end
        StHold: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            state_q      <= empty ? StIdle : StFetch;
          end
        end
        default: begin
          dout_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = int'(ADDR_W) - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [ADDR_W:0] rd_level_q;
  assign rd_level = rd_level_q;

  always_ff @(posedge clk_in) begin
    if (!reset_n) rd_level_q <= '0;
    else          rd_level_q <= gray2bin(sync2_q) - rd_ptr_bin_q;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: bench acts as write side and RAM, with a word-queue scoreboard.
module tb_fifo_rd_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk_in = 1'b0;
  logic          reset_n;
  logic [AW:0]   wr_ptr_gray_in;
  logic [AW:0]   rd_ptr_gray_out;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [AW:0]   rd_level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ram [2**AW];
  logic [AW:0]   wr_bin;
  logic [DW-1:0] exp_q [$];

  fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in          (clk_in),
    .reset_n         (reset_n),
    .wr_ptr_gray_in  (wr_ptr_gray_in),
    .rd_ptr_gray_out (rd_ptr_gray_out),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .dout_ready      (dout_ready),
    .empty           (empty)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level        (rd_level)
`endif
  );

  initial forever #5 clk_in = ~clk_in;

  // Registered-read RAM model.
  always @(posedge clk_in) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    ram[wr_bin[AW-1:0]] = d;
    exp_q.push_back(d);
    wr_bin = wr_bin + 1'b1;
    wr_ptr_gray_in = to_gray(wr_bin);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    dout_ready = 1'b0;
    wr_bin = '0;
    wr_ptr_gray_in = '0;
    exp_q.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dout_ready = 1'b0;
    wr_ptr_gray_in = 5'b00011;
    repeat (3) tick();
    n_tests++;
    if (dout_valid !== 1'b0 || empty !== 1'b1 || rd_ptr_gray_out !== '0 || dout !== '0 ||
        mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b empty=%b gray=%b dout=%h rd_en=%b, need 0 1 00000 00 0",
               dout_valid, empty, rd_ptr_gray_out, dout, mem_rd_en);
    end
    wr_bin = '0;
    wr_ptr_gray_in = '0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    apply_reset();
    w = DW'($urandom);
    write_word(w);
    tick();  // edge k
    n_tests++;
    if (empty !== 1'b1) begin
      n_fail++; $display("FAIL single_empty_k: empty=%b need 1", empty);
    end
    tick();  // edge k+1
    n_tests++;
    if (empty !== 1'b0 || mem_rd_en !== 1'b1 || mem_rd_addr !== '0 || dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read: empty=%b rd_en=%b addr=%0d valid=%b need 0 1 0 0",
               empty, mem_rd_en, mem_rd_addr, dout_valid);
    end
    tick();  // edge k+2
    n_tests++;
    if (mem_rd_en !== 1'b0 || dout_valid !== 1'b0 || rd_ptr_gray_out !== 5'b00001) begin
      n_fail++;
      $display("FAIL single_fetch: rd_en=%b valid=%b gray=%b need 0 0 00001",
               mem_rd_en, dout_valid, rd_ptr_gray_out);
    end
    tick();  // edge k+3
    n_tests++;
    if (dout_valid !== 1'b1 || dout !== w) begin
      n_fail++;
      $display("FAIL single_out: valid=%b dout=%h need 1 %h", dout_valid, dout, w);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    n_tests++;
    if (dout_valid !== 1'b0 || empty !== 1'b1 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: valid=%b empty=%b rd_en=%b need 0 1 0",
               dout_valid, empty, mem_rd_en);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w [3];
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      w[i] = DW'($urandom);
      write_word(w[i]);
      tick();
    end
    repeat (5) tick();
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if (dout_valid !== 1'b1 || dout !== w[0] || mem_rd_en !== 1'b0 ||
          rd_ptr_gray_out !== 5'b00001) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: valid=%b dout=%h rd_en=%b gray=%b need 1 %h 0 00001",
                 c, dout_valid, dout, mem_rd_en, rd_ptr_gray_out, w[0]);
      end
      tick();
    end
    dout_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      n_tests++;
      if (dout_valid !== 1'b0) begin
        n_fail++; $display("FAIL bp_gap%0d: valid=%b need 0", i, dout_valid);
      end
      tick();
      n_tests++;
      if (dout_valid !== 1'b1 || dout !== w[i]) begin
        n_fail++;
        $display("FAIL bp_word%0d: valid=%b dout=%h need 1 %h", i, dout_valid, dout, w[i]);
      end
    end
    tick();
    dout_ready = 1'b0;
    n_tests++;
    if (dout_valid !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL bp_end: valid=%b empty=%b need 0 1", dout_valid, empty);
    end
  endtask

  // Streams `total` words; percentages set write and ready activity. Ends with a drained FIFO.
  task automatic test_stream(input int total, input int wr_pct, input int rdy_pct,
                             input bit want_wrap);
    int wr_cnt = 0, pop_cnt = 0, cyc = 0;
    bit prev_valid = 0, prev_ready = 0, saw_wrap = 0;
    logic [DW-1:0] prev_dout = '0;
    logic [AW:0] prev_gray = '0;
    logic [DW-1:0] e;
    apply_reset();
    while (pop_cnt < total && cyc < 20000) begin
      if (prev_valid && !prev_ready) begin
        n_tests++;
        if (dout_valid !== 1'b1 || dout !== prev_dout) begin
          n_fail++;
          $display("FAIL stream_stable cyc%0d: valid=%b dout=%h need 1 %h",
                   cyc, dout_valid, dout, prev_dout);
        end
      end
      n_tests++;
      if (mem_rd_en && empty) begin
        n_fail++; $display("FAIL stream_rd_while_empty cyc%0d: rd_en=1 empty=1 need rd_en=0", cyc);
      end
      if (prev_gray == 5'b10000 && rd_ptr_gray_out == 5'b00000) saw_wrap = 1;
      prev_gray = rd_ptr_gray_out;
      dout_ready = ($urandom_range(99) < rdy_pct);
      if (dout_valid && dout_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_spurious cyc%0d: dout=%h with nothing written", cyc, dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            n_fail++; $display("FAIL stream_data #%0d: dout=%h need %h", pop_cnt, dout, e);
          end
        end
        pop_cnt++;
      end
      if (wr_cnt < total && (wr_cnt - pop_cnt) < 2**AW && $urandom_range(99) < wr_pct) begin
        write_word(DW'($urandom));
        wr_cnt++;
      end
      prev_valid = dout_valid;
      prev_ready = dout_ready;
      prev_dout  = dout;
      tick();
      cyc++;
    end
    n_tests++;
    if (pop_cnt != total) begin
      n_fail++; $display("FAIL stream_timeout: popped %0d need %0d", pop_cnt, total);
    end
    dout_ready = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (empty !== 1'b1 || dout_valid !== 1'b0 || rd_ptr_gray_out !== to_gray(wr_bin)) begin
      n_fail++;
      $display("FAIL stream_final: empty=%b valid=%b gray=%b need 1 0 %b",
               empty, dout_valid, rd_ptr_gray_out, to_gray(wr_bin));
    end
    if (want_wrap) begin
      n_tests++;
      if (!saw_wrap) begin
        n_fail++; $display("FAIL stream_wrap: gray 10000->00000 seen=%b need 1", saw_wrap);
      end
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    write_word(DW'($urandom));
    repeat (3) tick();  // now in FETCH
    reset_n = 1'b0;
    n_tests++;
    if (mem_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL midop_fetch_rd_en: rd_en=%b need 0", mem_rd_en);
    end
    tick();
    n_tests++;
    if (dout_valid !== 1'b0 || rd_ptr_gray_out !== '0 || dout !== '0 || mem_rd_en !== 1'b0 ||
        empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_reset: valid=%b gray=%b dout=%h rd_en=%b empty=%b need 0 0 00 0 1",
               dout_valid, rd_ptr_gray_out, dout, mem_rd_en, empty);
    end
    tick();
    n_tests++;
    if (mem_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL midop_hold_rd_en: rd_en=%b need 0", mem_rd_en);
    end
    wr_bin = '0;
    wr_ptr_gray_in = '0;
    exp_q.delete();
    reset_n = 1'b1;
    repeat (4) tick();
    n_tests++;
    if (dout_valid !== 1'b0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL midop_after: valid=%b empty=%b need 0 1", dout_valid, empty);
    end
  endtask

`ifdef FIFO_RD_LEVEL_EN
  task automatic test_level();
    logic [DW-1:0] w [6];
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      w[i] = DW'($urandom);
      write_word(w[i]);
      tick();
    end
    repeat (8) tick();
    n_tests++;
    if (rd_level !== 5'd5) begin
      n_fail++; $display("FAIL level_one_read: rd_level=%0d need 5", rd_level);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (rd_level !== 5'd4 || dout !== w[1]) begin
      n_fail++;
      $display("FAIL level_two_reads: rd_level=%0d dout=%h need 4 %h", rd_level, dout, w[1]);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    dout_ready = 1'b0;
    wr_bin = '0;
    wr_ptr_gray_in = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_stream(40, 100, 100, 1'b1);
    test_stream(200, 50, 40, 1'b0);
    test_reset_midop();
`ifdef FIFO_RD_LEVEL_EN
    test_level();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
